// File: rtl/cmd_bus_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cmd_bus_tx                                                 |
// | Description : Serialises a command opcode into a sequence of 3-bit       |
// |               symbols on bus_c, each framed by one bus_clk strobe pulse  |
// |               with programmable setup, high, hold and gap times.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cmd_bus_tx #(
   parameter int SETUP_CYC = 64,
   parameter int HIGH_CYC  = 64,
   parameter int HOLD_CYC  = 64,
   parameter int GAP_CYC   = 64
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       cmd_valid,
   input  logic [3:0] cmd_op,
   output logic       cmd_ready,
   output logic [2:0] bus_c,
   output logic       bus_clk,
   output logic       done,
   output logic       err
);

   // A zero-length phase would make the counter compare meaningless, so it becomes one cycle
   localparam int C_SETUP_EFF = (SETUP_CYC < 1) ? 1 : SETUP_CYC;
   localparam int C_HIGH_EFF  = (HIGH_CYC  < 1) ? 1 : HIGH_CYC;
   localparam int C_HOLD_EFF  = (HOLD_CYC  < 1) ? 1 : HOLD_CYC;
   localparam int C_GAP_EFF   = (GAP_CYC   < 1) ? 1 : GAP_CYC;
   localparam int C_MAX_AB    = (C_SETUP_EFF > C_HIGH_EFF) ? C_SETUP_EFF : C_HIGH_EFF;
   localparam int C_MAX_CD    = (C_HOLD_EFF  > C_GAP_EFF)  ? C_HOLD_EFF  : C_GAP_EFF;
   localparam int C_MAX_CYC   = (C_MAX_AB > C_MAX_CD) ? C_MAX_AB : C_MAX_CD;
   // The counter only ever holds 0 .. phase_length-1
   localparam int C_CNT_W     = (C_MAX_CYC > 1) ? $clog2(C_MAX_CYC) : 1;

   localparam logic [C_CNT_W-1:0] C_SETUP_LAST = C_CNT_W'(C_SETUP_EFF - 1);
   localparam logic [C_CNT_W-1:0] C_HIGH_LAST  = C_CNT_W'(C_HIGH_EFF  - 1);
   localparam logic [C_CNT_W-1:0] C_HOLD_LAST  = C_CNT_W'(C_HOLD_EFF  - 1);
   localparam logic [C_CNT_W-1:0] C_GAP_LAST   = C_CNT_W'(C_GAP_EFF   - 1);
   localparam logic [C_CNT_W-1:0] C_CNT_ONE    = C_CNT_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_HIGH  = 3'd2,
      ST_HOLD  = 3'd3,
      ST_GAP   = 3'd4
   } state_t;

   state_t               r_state, w_state_nxt;
   logic [C_CNT_W-1:0]   r_cnt,   w_cnt_nxt;
   logic [2:0]           r_idx,   w_idx_nxt;
   logic [3:0]           r_op,    w_op_nxt;
   logic [2:0]           r_bus_c, w_bus_c_nxt;
   logic                 r_bus_clk, w_bus_clk_nxt;
   logic                 r_done,  w_done_nxt;
   logic                 r_err,   w_err_nxt;
   logic                 w_op_ok;
   logic                 w_last_sym;

   // Number of symbols making up each opcode's command
   function automatic logic [2:0] sym_len(input logic [3:0] op);
      logic [2:0] n;
      n = 3'd1;
      case (op)
         4'd5:       n = 3'd2;
         4'd7, 4'd8: n = 3'd5;
         default:    n = 3'd1;
      endcase
      return n;
   endfunction

   // Symbol number idx of the command for opcode op
   function automatic logic [2:0] sym_at(input logic [3:0] op, input logic [2:0] idx);
      logic [2:0] s;
      s = 3'd0;
      case (op)
         4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6: s = op[2:0];
         4'd5: s = (idx == 3'd0) ? 3'd5 : 3'd0;
         4'd7, 4'd8: begin
            case (idx)
               3'd0, 3'd2: s = 3'd7;
               3'd4:       s = (op == 4'd8) ? 3'd3 : 3'd1;
               default:    s = 3'd0;
            endcase
         end
         default: s = 3'd0;
      endcase
      return s;
   endfunction

   assign w_op_ok    = (cmd_op <= 4'd8);
   assign w_last_sym = (r_idx == (sym_len(r_op) - 3'd1));

   // Next-state and next-output decode; every output is registered below
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_idx_nxt     = r_idx;
      w_op_nxt      = r_op;
      w_bus_c_nxt   = r_bus_c;
      w_bus_clk_nxt = r_bus_clk;
      w_done_nxt    = 1'b0;
      w_err_nxt     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (cmd_valid) begin
               if (w_op_ok) begin
                  w_state_nxt   = ST_SETUP;
                  w_cnt_nxt     = '0;
                  w_idx_nxt     = 3'd0;
                  w_op_nxt      = cmd_op;
                  w_bus_c_nxt   = sym_at(cmd_op, 3'd0);
                  w_bus_clk_nxt = 1'b0;
               end else begin
                  w_err_nxt = 1'b1;
               end
            end
         end
         ST_SETUP: begin
            if (r_cnt == C_SETUP_LAST) begin
               w_state_nxt   = ST_HIGH;
               w_cnt_nxt     = '0;
               w_bus_clk_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + C_CNT_ONE;
            end
         end
         ST_HIGH: begin
            if (r_cnt == C_HIGH_LAST) begin
               w_state_nxt   = ST_HOLD;
               w_cnt_nxt     = '0;
               w_bus_clk_nxt = 1'b0;
            end else begin
               w_cnt_nxt = r_cnt + C_CNT_ONE;
            end
         end
         ST_HOLD: begin
            if (r_cnt == C_HOLD_LAST) begin
               w_state_nxt = ST_GAP;
               w_cnt_nxt   = '0;
               w_bus_c_nxt = 3'd0;
            end else begin
               w_cnt_nxt = r_cnt + C_CNT_ONE;
            end
         end
         ST_GAP: begin
            if (r_cnt == C_GAP_LAST) begin
               w_cnt_nxt = '0;
               if (w_last_sym) begin
                  w_state_nxt = ST_IDLE;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_state_nxt = ST_SETUP;
                  w_idx_nxt   = r_idx + 3'd1;
                  w_bus_c_nxt = sym_at(r_op, r_idx + 3'd1);
               end
            end else begin
               w_cnt_nxt = r_cnt + C_CNT_ONE;
            end
         end
         default: begin
            w_state_nxt   = ST_IDLE;
            w_cnt_nxt     = '0;
            w_bus_c_nxt   = 3'd0;
            w_bus_clk_nxt = 1'b0;
         end
      endcase
   end

   // State register; reset aborts any command and drops the strobe at once
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_idx     <= 3'd0;
         r_op      <= 4'd0;
         r_bus_c   <= 3'd0;
         r_bus_clk <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_idx     <= w_idx_nxt;
         r_op      <= w_op_nxt;
         r_bus_c   <= w_bus_c_nxt;
         r_bus_clk <= w_bus_clk_nxt;
         r_done    <= w_done_nxt;
         r_err     <= w_err_nxt;
      end
   end

   assign cmd_ready = (r_state == ST_IDLE);
   assign bus_c     = r_bus_c;
   assign bus_clk   = r_bus_clk;
   assign done      = r_done;
   assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cmd_bus_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_cmd_bus_tx                                              |
// | Description : Scoreboard bench for cmd_bus_tx with default timing.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_cmd_bus_tx;

   localparam int C_SETUP   = 64;
   localparam int C_HIGH    = 64;
   localparam int C_SYM_CYC = 256;
   localparam int EV_SYM    = 0;
   localparam int EV_DONE   = 1;
   localparam int EV_ERR    = 2;

   typedef struct {
      int kind;
      int val;
      int cyc;
   } ev_t;

   logic       clk = 1'b0;
   logic       rstn;
   logic       cmd_valid;
   logic [3:0] cmd_op;
   logic       cmd_ready;
   logic [2:0] bus_c;
   logic       bus_clk;
   logic       done;
   logic       err;

   int  cyc = 0;
   int  n_assert = 0;
   int  n_fail = 0;
   ev_t exp_q[$];

   int seq_len [9] = '{1, 1, 1, 1, 1, 2, 1, 5, 5};
   int seq_sym [9][5] = '{
      '{0, 0, 0, 0, 0}, '{1, 0, 0, 0, 0}, '{2, 0, 0, 0, 0},
      '{3, 0, 0, 0, 0}, '{4, 0, 0, 0, 0}, '{5, 0, 0, 0, 0},
      '{6, 0, 0, 0, 0}, '{7, 0, 7, 0, 1}, '{7, 0, 7, 0, 3}};

   cmd_bus_tx dut (
      .clk       (clk),
      .rstn      (rstn),
      .cmd_valid (cmd_valid),
      .cmd_op    (cmd_op),
      .cmd_ready (cmd_ready),
      .bus_c     (bus_c),
      .bus_clk   (bus_clk),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int expv);
      n_assert++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic push_ev(input int kind, input int val, input int c);
      ev_t e;
      e.kind = kind;
      e.val  = val;
      e.cyc  = c;
      exp_q.push_back(e);
   endtask

   // Expected falling-edge symbols (first nsym of them) and optional done
   task automatic expect_cmd(input int op, input int acc, input int nsym, input bit with_done);
      for (int i = 0; i < nsym; i++)
         push_ev(EV_SYM, seq_sym[op][i], acc + i * C_SYM_CYC + C_SETUP + C_HIGH);
      if (with_done)
         push_ev(EV_DONE, 0, acc + seq_len[op] * C_SYM_CYC);
   endtask

   task automatic got(input int kind, input int val);
      ev_t e;
      n_assert++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL unexpected_event: got kind %0d val %0d at cycle %0d, required no event",
                  kind, val, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.val != val || e.cyc != cyc) begin
            n_fail++;
            $display("FAIL event: got kind %0d val %0d cycle %0d, required kind %0d val %0d cycle %0d",
                     kind, val, cyc, e.kind, e.val, e.cyc);
         end
      end
   endtask

   // Monitor: turns DUT outputs into events and scores them against the queue
   bit       prev_clk = 1'b0;
   int       rise_cyc = 0;
   int       rise_c = 0;
   always @(negedge clk) begin
      if (rstn !== 1'b1) begin
         prev_clk = 1'b0;
      end else begin
         if (err === 1'b1) got(EV_ERR, 0);
         if (bus_clk === 1'b1 && !prev_clk) begin
            rise_cyc = cyc;
            rise_c   = int'(bus_c);
         end
         if (bus_clk === 1'b0 && prev_clk) begin
            check("strobe_width", cyc - rise_cyc, C_HIGH);
            check("bus_c_stable_while_high", int'(bus_c), rise_c);
            got(EV_SYM, int'(bus_c));
         end
         if (done === 1'b1) got(EV_DONE, 0);
         prev_clk = (bus_clk === 1'b1);
      end
   end

   // Present a command at a falling edge; acc is the acceptance edge's cycle number
   task automatic offer(input logic [3:0] op, output int acc);
      acc = -1;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      for (int k = 0; k < 4000; k++) begin
         if (cmd_ready === 1'b1) begin
            acc = cyc + 1;
            break;
         end
         @(negedge clk);
      end
      if (acc < 0) begin
         n_assert++;
         n_fail++;
         $display("FAIL accept_timeout: got cmd_ready 0, required 1 for op %0d", op);
      end
   endtask

   task automatic drop();
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int k;
      for (k = 0; k < 3000; k++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      if (k == 3000) begin
         n_assert++;
         n_fail++;
         $display("FAIL idle_timeout: got %0d pending events, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test, required completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail + 1);
      $fatal(1, "watchdog");
   end

   int acc;
   int acc2;
   int bad;
   int single_ops [5] = '{0, 2, 3, 4, 6};
   int bad_ops [3] = '{12, 9, 15};

   initial begin
      rstn      = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 4'd0;
      repeat (3) @(negedge clk);
      check("reset_bus_c", int'(bus_c), 0);
      check("reset_bus_clk", int'(bus_clk), 0);
      check("reset_done", int'(done), 0);
      check("reset_err", int'(err), 0);
      check("reset_cmd_ready", int'(cmd_ready), 1);

      // PLUS waiting at reset release is taken on the first edge
      rstn      = 1'b1;
      cmd_valid = 1'b1;
      cmd_op    = 4'd1;
      acc       = cyc + 1;
      expect_cmd(1, acc, 1, 1'b1);
      drop();
      check("plus_first_symbol", int'(bus_c), 1);
      check("plus_ready_low", int'(cmd_ready), 0);
      wait_idle();

      // Single-symbol opcodes
      foreach (single_ops[i]) begin
         offer(4'(single_ops[i]), acc);
         expect_cmd(single_ops[i], acc, 1, 1'b1);
         drop();
         wait_idle();
      end

      // DISCHARGE_B with an invalid opcode held valid while busy
      offer(4'd8, acc);
      expect_cmd(8, acc, 5, 1'b1);
      @(posedge clk);
      #1 cmd_op = 4'd12;
      bad = 0;
      for (int k = 0; k < 1280; k++) begin
         @(negedge clk);
         if (cmd_ready !== 1'b0) bad++;
      end
      cmd_valid = 1'b0;
      check("discharge_b_ready_low_cycles", bad, 0);
      wait_idle();

      // Invalid opcodes in IDLE
      foreach (bad_ops[i]) begin
         offer(4'(bad_ops[i]), acc);
         push_ev(EV_ERR, 0, acc);
         drop();
      end
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (bus_clk !== 1'b0 || cmd_ready !== 1'b1) bad++;
      end
      check("invalid_op_stays_idle", bad, 0);
      wait_idle();

      // START, then SHUTDOWN held valid throughout
      offer(4'd5, acc);
      expect_cmd(5, acc, 2, 1'b1);
      @(posedge clk);
      #1 cmd_op = 4'd6;
      acc2 = -1;
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (cmd_ready === 1'b1) begin
            acc2 = cyc + 1;
            break;
         end
      end
      check("shutdown_accept_cycle", acc2, acc + 513);
      expect_cmd(6, acc2, 1, 1'b1);
      drop();
      wait_idle();

      // Reset during the high phase of the third DISCHARGE_P symbol
      offer(4'd7, acc);
      expect_cmd(7, acc, 2, 1'b0);
      drop();
      while (cyc < acc + 2 * C_SYM_CYC + C_SETUP + 10) @(negedge clk);
      check("strobe_high_before_reset", int'(bus_clk), 1);
      #2 rstn = 1'b0;
      #1;
      check("abort_bus_clk", int'(bus_clk), 0);
      check("abort_bus_c", int'(bus_c), 0);
      check("abort_done", int'(done), 0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      check("abort_queue_empty", exp_q.size(), 0);
      offer(4'd0, acc);
      expect_cmd(0, acc, 1, 1'b1);
      drop();
      wait_idle();

      repeat (20) @(negedge clk);
      check("final_queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cmd_bus_tx.md
CMD_BUS_TX -- requirements
Module: cmd_bus_tx

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 64: clk cycles from bus data change to strobe rise.
REQ-002 SHALL have parameter HIGH_CYC, default 64: clk cycles the strobe is held high.
REQ-003 SHALL have parameter HOLD_CYC, default 64: clk cycles bus data is held after strobe fall.
REQ-004 SHALL have parameter GAP_CYC, default 64: idle clk cycles between consecutive symbols of one command.
REQ-005 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-006 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port cmd_valid  input  1  command request valid.
REQ-008 SHALL have port cmd_op  input  4  command opcode (see REQ-014).
REQ-009 SHALL have port cmd_ready  output  1  high when a command is accepted this cycle if cmd_valid is high.
REQ-010 SHALL have port bus_c  output  3  command symbol to far-end C0..C2.
REQ-011 SHALL have port bus_clk  output  1  strobe; far end samples bus_c on its falling edge.
REQ-012 SHALL have port done  output  1  one-cycle pulse after last symbol's HOLD and GAP complete.
REQ-013 SHALL have port err  output  1  one-cycle pulse when an invalid opcode is offered.

Function
REQ-014 Opcode map SHALL be: 0 PAUSE->{0}; 1 PLUS->{1}; 2 MINUS->{2}; 3 BALLAST_P->{3}; 4 BALLAST_N->{4}; 5 START->{5,0}; 6 SHUTDOWN->{6}; 7 DISCHARGE_P->{7,0,7,0,1}; 8 DISCHARGE_B->{7,0,7,0,3}; 9-15 invalid.
REQ-015 Transfer SHALL occur on a cycle with cmd_valid=1 and cmd_ready=1; cmd_op sampled that cycle only.
REQ-016 cmd_ready SHALL be 1 only in IDLE state.
REQ-017 Invalid opcode with cmd_valid=1 in IDLE SHALL pulse err one cycle after, not start a transfer, remain in IDLE.
REQ-018 FSM states SHALL be IDLE, SETUP, HIGH, HOLD, GAP.
REQ-019 IDLE->SETUP on valid transfer: cycle after acceptance bus_c = first symbol, bus_clk=0, symbol index=0.
REQ-020 SETUP SHALL last SETUP_CYC cycles, then HIGH: bus_clk=1 for HIGH_CYC cycles.
REQ-021 HIGH->HOLD: bus_clk=0, bus_c unchanged for HOLD_CYC cycles.
REQ-022 HOLD->GAP: bus_c=0, bus_clk=0 for GAP_CYC cycles.
REQ-023 GAP end: if more symbols, index+1, next symbol on bus_c, go SETUP; else pulse done, go IDLE.
REQ-024 bus_c SHALL never change while bus_clk=1 or in HOLD; bus_clk SHALL never glitch (registered outputs).
REQ-025 Per-state counter SHALL be wide enough for max(SETUP_CYC,HIGH_CYC,HOLD_CYC,GAP_CYC); any parameter of 0 SHALL be treated as 1.
REQ-026 cmd_valid/cmd_op changes while not IDLE SHALL be ignored; no queuing.
REQ-027 done SHALL pulse in the same cycle cmd_ready returns to 1; a new command accepted that cycle begins immediately.
REQ-028 Total command duration SHALL be 1 + N*(SETUP_CYC+HIGH_CYC+HOLD_CYC+GAP_CYC) cycles from acceptance to done for N symbols.

Reset
REQ-029 rstn=0 SHALL asynchronously force IDLE, bus_c=0, bus_clk=0, done=0, err=0, cmd_ready=1 (after release), counters=0.
REQ-030 Reset mid-transfer SHALL abort the command with no done pulse; bus_clk drops to 0 immediately.
REQ-031 After rstn release, first command SHALL be acceptable on the first clk edge.

Verification
REQ-032 PLUS (op 1), defaults -> one bus_clk pulse 64 cycles high, bus_c=1 stable from 64 cycles before rise to 64 after fall; done at cycle 257.
REQ-033 DISCHARGE_B (op 8) -> five falling edges with bus_c sequence 7,0,7,0,3; done at cycle 1281; cmd_ready=0 throughout.
REQ-034 op 12 offered in IDLE -> err pulse next cycle, bus_clk stays 0, cmd_ready stays 1.
REQ-035 START (op 5) then SHUTDOWN held valid during transfer -> only 5,0 sent first; op 6 accepted in done cycle, symbol 6 follows.
REQ-036 rstn low during HIGH of symbol 3 of DISCHARGE_P -> bus_clk=0, bus_c=0 immediately, no done; next PAUSE sends single 0.
REQ-037 Loopback to the receiving controller: START then PLUS after 16 s -> receiver asserts O_PLUS, O_TOP_1, O_BOT_2.
